// File: rtl/afifo_seq_checker_pkg.sv
// Shared types and the pattern step function used by the AFIFO sequence checker.
// Both counter mode and LFSR mode share a single next_word() implementation.
package afifo_seq_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        CHECK = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam int MODE_COUNTER = 0;
    localparam int MODE_LFSR    = 1;
    localparam int MAX_W        = 64;

    // Operands are zero-extended to MAX_W; the result is masked back to w bits so counter mode wraps mod 2^w.
    function automatic logic [MAX_W-1:0] next_word(
        input logic [MAX_W-1:0] x,
        input int               w,
        input logic [MAX_W-1:0] step,
        input logic [MAX_W-1:0] taps,
        input int               mode
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] y;
        mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
        if (mode == MODE_LFSR) begin
            y = x[0] ? ((x >> 1) ^ taps) : (x >> 1);
        end else begin
            y = x + step;
        end
        return y & mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear.
// Once the count reaches all-ones it holds there until clr or reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/afifo_seq_checker.sv
// Drains an AFIFO read port and checks that consecutive words follow a counter or LFSR pattern.
// Keeps saturating statistics and captures the first failing word.
//
// state | meaning
// IDLE  | checking disabled, no reads
// SEED  | reading, waiting for a usable seed word
// CHECK | reading, comparing each word against the predicted value
// HALT  | stopped after an error, no reads until clr or en=0
module afifo_seq_checker
    import afifo_seq_checker_pkg::*;
#(
    parameter int           W            = 12,
    parameter int           MODE         = MODE_COUNTER,
    parameter logic [W-1:0] STEP         = W'(1),
    parameter logic [W-1:0] TAPS         = W'(12'hE08),
    parameter bit           STOP_ON_FAIL = 1'b1,
    parameter int           CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    output logic             r,
    input  logic             rok,
    input  logic [W-1:0]     rd,
    output logic             fail,
    output logic             locked,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [W-1:0]     bad_want,
    output logic [W-1:0]     bad_got
);

    state_t       state_q;
    state_t       state_d;
    logic [W-1:0] expected;
    logic [W-1:0] nxt;
    logic         live;
    logic         xfer;
    logic         lfsr_zero;
    logic         seed_ok;
    logic         chk;
    logic         mism;

    // A transfer during clr or en=0 still pops the FIFO but is otherwise ignored.
    assign live      = en && !clr;
    assign xfer      = r && rok;
    assign lfsr_zero = (MODE == MODE_LFSR) && (rd == '0);
    assign nxt       = W'(next_word(MAX_W'(rd), W, MAX_W'(STEP), MAX_W'(TAPS), MODE));
    assign seed_ok   = live && xfer && (state_q == SEED) && !lfsr_zero;
    assign chk       = live && xfer && (state_q == CHECK);
    assign mism      = chk && ((rd != expected) || lfsr_zero);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = en ? SEED : IDLE;
        end else if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = SEED;
                SEED:    if (seed_ok) state_d = CHECK;
                CHECK:   if (mism && STOP_ON_FAIL) state_d = HALT;
                HALT:    state_d = HALT;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        r = (state_q == SEED) || (state_q == CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= '0;
            fail     <= 1'b0;
            locked   <= 1'b0;
            bad_want <= '0;
            bad_got  <= '0;
        end else if (clr) begin
            fail     <= 1'b0;
            locked   <= 1'b0;
            bad_want <= '0;
            bad_got  <= '0;
        end else if (!en) begin
            locked <= 1'b0;
        end else begin
            if (seed_ok) begin
                expected <= nxt;
                locked   <= 1'b1;
            end
            if (chk && (!mism || !STOP_ON_FAIL)) begin
                expected <= nxt;
            end
            if (mism) begin
                fail <= 1'b1;
                if (!fail) begin
                    bad_want <= expected;
                    bad_got  <= rd;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_word_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (seed_ok || chk),
        .clr   (clr),
        .cnt   (word_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mism),
        .clr   (clr),
        .cnt   (err_cnt)
    );

endmodule

// File: tb/tb_afifo_seq_checker.sv
// Bench for afifo_seq_checker: three checker configurations, each fed by a queue-modelled FIFO,
// checked against a stream-level reference model of the expected statistics.
module tb_afifo_seq_checker;

    localparam int W  = 12;
    localparam int CW = 16;
    typedef logic [W-1:0] word_t;
    typedef struct packed {
        int    consumed;
        int    wc;
        int    ec;
        bit    f;
        bit    lk;
        word_t bw;
        word_t bg;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en     [3];
    logic          clr    [3];
    logic          r      [3];
    logic          rok    [3];
    word_t         rd     [3];
    logic          fail   [3];
    logic          locked [3];
    logic [CW-1:0] wcnt   [3];
    logic [CW-1:0] ecnt   [3];
    word_t         bw     [3];
    word_t         bg     [3];
    word_t         fq0[$];
    word_t         fq1[$];
    word_t         fq2[$];
    int            checks  = 0;
    int            errors  = 0;
    int            gap_pct = 0;

    always #5 clk = ~clk;

    // 0: counter, stop on fail   1: counter, resync   2: LFSR, resync
    afifo_seq_checker #(.W(W), .MODE(0), .STEP(12'd1), .TAPS(12'hE08), .STOP_ON_FAIL(1'b1), .CNT_W(CW)) u_stop (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .clr(clr[0]), .r(r[0]), .rok(rok[0]), .rd(rd[0]),
        .fail(fail[0]), .locked(locked[0]), .word_cnt(wcnt[0]), .err_cnt(ecnt[0]), .bad_want(bw[0]), .bad_got(bg[0]));
    afifo_seq_checker #(.W(W), .MODE(0), .STEP(12'd1), .TAPS(12'hE08), .STOP_ON_FAIL(1'b0), .CNT_W(CW)) u_resync (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .clr(clr[1]), .r(r[1]), .rok(rok[1]), .rd(rd[1]),
        .fail(fail[1]), .locked(locked[1]), .word_cnt(wcnt[1]), .err_cnt(ecnt[1]), .bad_want(bw[1]), .bad_got(bg[1]));
    afifo_seq_checker #(.W(W), .MODE(1), .STEP(12'd1), .TAPS(12'hE08), .STOP_ON_FAIL(1'b0), .CNT_W(CW)) u_lfsr (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .clr(clr[2]), .r(r[2]), .rok(rok[2]), .rd(rd[2]),
        .fail(fail[2]), .locked(locked[2]), .word_cnt(wcnt[2]), .err_cnt(ecnt[2]), .bad_want(bw[2]), .bad_got(bg[2]));

    function automatic int fsize(input int i);
        case (i)
            0:       return fq0.size();
            1:       return fq1.size();
            default: return fq2.size();
        endcase
    endfunction

    function automatic word_t ffront(input int i);
        case (i)
            0:       return fq0[0];
            1:       return fq1[0];
            default: return fq2[0];
        endcase
    endfunction

    task automatic fpush(input int i, input word_t w);
        case (i)
            0:       fq0.push_back(w);
            1:       fq1.push_back(w);
            default: fq2.push_back(w);
        endcase
    endtask

    task automatic fpop(input int i);
        case (i)
            0:       void'(fq0.pop_front());
            1:       void'(fq1.pop_front());
            default: void'(fq2.pop_front());
        endcase
    endtask

    task automatic fflush(input int i);
        case (i)
            0:       fq0.delete();
            1:       fq1.delete();
            default: fq2.delete();
        endcase
    endtask

    function automatic word_t nxt(input word_t x, input bit lfsr);
        if (lfsr) return x[0] ? ((x >> 1) ^ 12'hE08) : (x >> 1);
        return x + W'(1);
    endfunction

    // Stream-level prediction: walks the words the FIFO would hand over, in order.
    function automatic res_t model(input word_t s[$], input bit lfsr, input bit stop);
        res_t  m;
        word_t exp_w;
        m     = '0;
        exp_w = '0;
        for (int k = 0; k < s.size(); k++) begin
            if (stop && m.f) break;
            m.consumed++;
            if (!m.lk) begin
                if (!(lfsr && s[k] == '0)) begin
                    m.lk  = 1'b1;
                    m.wc++;
                    exp_w = nxt(s[k], lfsr);
                end
            end else begin
                m.wc++;
                if (s[k] !== exp_w || (lfsr && s[k] == '0)) begin
                    m.ec++;
                    if (!m.f) begin
                        m.bw = exp_w;
                        m.bg = s[k];
                    end
                    m.f = 1'b1;
                end
                exp_w = nxt(s[k], lfsr);
            end
        end
        return m;
    endfunction

    // One clock: present FIFO heads at negedge, pop on transfer, settle #1 after posedge.
    task automatic tick();
        logic rpre [3];
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rok[i]  = (fsize(i) > 0) && ($urandom_range(99) >= gap_pct);
            rd[i]   = rok[i] ? ffront(i) : W'($urandom);
            rpre[i] = r[i];
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) if (rpre[i] && rok[i]) fpop(i);
        #1;
    endtask

    task automatic start(input int i);
        for (int j = 0; j < 3; j++) begin
            en[j]  = 1'b0;
            clr[j] = 1'b0;
        end
        tick();
        fflush(i);
        clr[i] = 1'b1;
        tick();
        clr[i] = 1'b0;
        en[i]  = 1'b1;
    endtask

    task automatic run_until(input int i, input int target);
        int n;
        n = 0;
        while (fsize(i) > target && n < 2000) begin
            tick();
            n++;
        end
        repeat (4) tick();
    endtask

    task automatic expect_model(input int i, input word_t s[$], input bit lfsr, input bit stop, input string tag);
        res_t m;
        int   left;
        m    = model(s, lfsr, stop);
        left = s.size() - m.consumed;
        run_until(i, left);
        checks++; if (fsize(i) !== left) begin errors++; $display("FAIL %s fifo_left: got %0d want %0d", tag, fsize(i), left); end
        checks++; if (wcnt[i] !== CW'(m.wc)) begin errors++; $display("FAIL %s word_cnt: got %0d want %0d", tag, wcnt[i], m.wc); end
        checks++; if (ecnt[i] !== CW'(m.ec)) begin errors++; $display("FAIL %s err_cnt: got %0d want %0d", tag, ecnt[i], m.ec); end
        checks++; if (fail[i] !== m.f) begin errors++; $display("FAIL %s fail: got %0b want %0b", tag, fail[i], m.f); end
        checks++; if (bw[i] !== m.bw) begin errors++; $display("FAIL %s bad_want: got %0h want %0h", tag, bw[i], m.bw); end
        checks++; if (bg[i] !== m.bg) begin errors++; $display("FAIL %s bad_got: got %0h want %0h", tag, bg[i], m.bg); end
        if (!(stop && m.f)) begin
            checks++; if (locked[i] !== m.lk) begin errors++; $display("FAIL %s locked: got %0b want %0b", tag, locked[i], m.lk); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0; clr[i] = 1'b0; rok[i] = 1'b0; rd[i] = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            checks++; if ({r[i], fail[i], locked[i]} !== 3'b000) begin errors++; $display("FAIL reset_flags[%0d]: got %b want 000", i, {r[i], fail[i], locked[i]}); end
            checks++; if (wcnt[i] !== '0 || ecnt[i] !== '0) begin errors++; $display("FAIL reset_cnt[%0d]: got %0d/%0d want 0/0", i, wcnt[i], ecnt[i]); end
            checks++; if (bw[i] !== '0 || bg[i] !== '0) begin errors++; $display("FAIL reset_bad[%0d]: got %0h/%0h want 0/0", i, bw[i], bg[i]); end
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        word_t hist[$];
        start(0);
        gap_pct = 0;
        hist = '{12'hFFD, 12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002, 12'h003};
        foreach (hist[k]) fpush(0, hist[k]);
        expect_model(0, hist, 1'b0, 1'b1, "wrap");
        checks++; if (wcnt[0] !== 16'd7 || fail[0] !== 1'b0 || locked[0] !== 1'b1) begin
            errors++; $display("FAIL wrap_const: got wc=%0d fail=%0b locked=%0b want 7/0/1", wcnt[0], fail[0], locked[0]);
        end
    endtask

    task automatic test_stop_on_fail();
        word_t hist[$];
        int    n;
        start(0);
        gap_pct = 0;
        hist = '{12'd5, 12'd6, 12'd7, 12'd9, 12'd10};
        foreach (hist[k]) fpush(0, hist[k]);
        n = 0;
        while (!fail[0] && n < 30) begin
            tick();
            n++;
        end
        checks++; if (fail[0] !== 1'b1) begin errors++; $display("FAIL stop_fail_rise: got %0b want 1", fail[0]); end
        checks++; if (r[0] !== 1'b0) begin errors++; $display("FAIL stop_r_drop: got %0b want 0", r[0]); end
        expect_model(0, hist, 1'b0, 1'b1, "stop");
        checks++; if (bw[0] !== 12'd8 || bg[0] !== 12'd9) begin errors++; $display("FAIL stop_bad: got %0d/%0d want 8/9", bw[0], bg[0]); end
        checks++; if (wcnt[0] !== 16'd4) begin errors++; $display("FAIL stop_wc: got %0d want 4", wcnt[0]); end
        checks++; if (fsize(0) !== 1 || ffront(0) !== 12'd10) begin errors++; $display("FAIL stop_left: got %0d words want 1 (10)", fsize(0)); end
    endtask

    task automatic test_resync();
        word_t hist[$];
        start(1);
        gap_pct = 25;
        hist = '{12'd5, 12'd6, 12'd7, 12'd9, 12'd10, 12'd11, 12'd13};
        foreach (hist[k]) fpush(1, hist[k]);
        expect_model(1, hist, 1'b0, 1'b0, "resync");
        checks++; if (ecnt[1] !== 16'd2 || wcnt[1] !== 16'd7) begin errors++; $display("FAIL resync_cnt: got %0d/%0d want 2/7", ecnt[1], wcnt[1]); end
        checks++; if (bw[1] !== 12'd8 || bg[1] !== 12'd9) begin errors++; $display("FAIL resync_bad: got %0d/%0d want 8/9", bw[1], bg[1]); end
    endtask

    task automatic test_lfsr();
        word_t hist[$];
        word_t x;
        start(2);
        gap_pct = 0;
        hist.push_back(12'h000);
        fpush(2, 12'h000);
        run_until(2, 0);
        checks++; if (locked[2] !== 1'b0 || wcnt[2] !== '0) begin errors++; $display("FAIL lfsr_zero_seed: got locked=%0b wc=%0d want 0/0", locked[2], wcnt[2]); end
        gap_pct = 20;
        hist.push_back(12'h001); fpush(2, 12'h001);
        hist.push_back(12'hE08); fpush(2, 12'hE08);
        x = 12'hE08;
        for (int k = 0; k < 199; k++) begin
            x = nxt(x, 1'b1);
            hist.push_back(x);
            fpush(2, x);
        end
        expect_model(2, hist, 1'b1, 1'b0, "lfsr");
        checks++; if (fail[2] !== 1'b0 || wcnt[2] !== 16'd201) begin errors++; $display("FAIL lfsr_200: got fail=%0b wc=%0d want 0/201", fail[2], wcnt[2]); end
    endtask

    task automatic test_clr_collision();
        start(0);
        gap_pct = 0;
        fpush(0, 12'd20); fpush(0, 12'd21); fpush(0, 12'd22);
        run_until(0, 0);
        fpush(0, 12'd99);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        checks++; if (fail[0] !== 1'b0 || locked[0] !== 1'b0) begin errors++; $display("FAIL clr_flags: got fail=%0b locked=%0b want 0/0", fail[0], locked[0]); end
        checks++; if (wcnt[0] !== '0 || ecnt[0] !== '0) begin errors++; $display("FAIL clr_cnt: got %0d/%0d want 0/0", wcnt[0], ecnt[0]); end
        checks++; if (r[0] !== 1'b1 || fsize(0) !== 0) begin errors++; $display("FAIL clr_seed: got r=%0b left=%0d want 1/0", r[0], fsize(0)); end
        fpush(0, 12'd50); fpush(0, 12'd51); fpush(0, 12'd52);
        run_until(0, 0);
        checks++; if (wcnt[0] !== 16'd3 || ecnt[0] !== '0 || fail[0] !== 1'b0 || locked[0] !== 1'b1) begin
            errors++; $display("FAIL clr_reseed: got wc=%0d ec=%0d fail=%0b locked=%0b want 3/0/0/1", wcnt[0], ecnt[0], fail[0], locked[0]);
        end
    endtask

    task automatic test_reset_mid();
        int left;
        start(1);
        gap_pct = 0;
        for (int k = 100; k < 140; k++) fpush(1, (k == 105) ? 12'd200 : W'(k));
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({r[1], fail[1], locked[1]} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b want 000", {r[1], fail[1], locked[1]}); end
        checks++; if (wcnt[1] !== '0 || ecnt[1] !== '0) begin errors++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", wcnt[1], ecnt[1]); end
        checks++; if (bw[1] !== '0 || bg[1] !== '0) begin errors++; $display("FAIL rstmid_bad: got %0h/%0h want 0/0", bw[1], bg[1]); end
        repeat (2) tick();
        rst_n = 1'b1;
        left = fsize(1);
        run_until(1, 0);
        checks++; if (fail[1] !== 1'b0 || ecnt[1] !== '0 || locked[1] !== 1'b1) begin errors++; $display("FAIL rstmid_clean: got fail=%0b ec=%0d locked=%0b want 0/0/1", fail[1], ecnt[1], locked[1]); end
        checks++; if (wcnt[1] !== CW'(left)) begin errors++; $display("FAIL rstmid_wc: got %0d want %0d", wcnt[1], left); end
    endtask

    task automatic test_random();
        word_t hist[$];
        word_t x;
        word_t w;
        int    len;
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < 3; i++) begin
                start(i);
                hist.delete();
                gap_pct = $urandom_range(40);
                len     = $urandom_range(40, 10);
                x       = (i == 2) ? W'($urandom_range(4095, 1)) : W'($urandom);
                for (int k = 0; k < len; k++) begin
                    w = x;
                    if ($urandom_range(9) == 0) w = x ^ W'($urandom_range(4095, 1));
                    hist.push_back(w);
                    fpush(i, w);
                    x = nxt(x, i == 2);
                end
                expect_model(i, hist, i == 2, i == 0, "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_stop_on_fail();
        test_resync();
        test_lfsr();
        test_clr_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
